// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and constants for the UART FIFO core.
//   parity_t    : parity mode selector (none / even / odd)
//   tx_state_t  : transmit FSM states
//   rx_state_t  : receive FSM states
//   MIN_CLKDIV  : smallest usable divisor; smaller requests are raised to it
//   effectiveDiv: clamps a requested divisor to MIN_CLKDIV
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  localparam logic [15:0] MIN_CLKDIV = 16'd4;

  function automatic logic [15:0] effectiveDiv(input logic [15:0] div);
    effectiveDiv = (div < MIN_CLKDIV) ? MIN_CLKDIV : div;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo -- single-clock show-ahead FIFO used for both UART directions.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write pushData (ignored when full)
//   pop        : advance the head (ignored when empty)
//   popData    : current head entry, forced to zero while empty
//   full/empty : occupancy status
//   level      : number of stored entries, 0..DEPTH
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         popData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;
  logic             doPush;
  logic             doPop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign level   = count;
  assign doPush  = push && !full;
  assign doPop   = pop && !empty;
  // Head is read combinationally so the consumer sees data with its valid.
  assign popData = empty ? '0 : mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo_core.sv
// uart_fifo_core -- UART transmitter/receiver with TX and RX FIFOs.
//   clk, rst_n             : clock, asynchronous active-low reset
//   clkdiv                 : clock cycles per bit (values below 4 act as 4)
//   tx_data/tx_valid/tx_ready : TX FIFO enqueue handshake
//   tx                     : serial output, idle high
//   rx                     : asynchronous serial input
//   rx_data/rx_valid/rx_ready : RX FIFO dequeue handshake
//   err_clr                : clears the sticky error flags
//   parity_err, frame_err, overrun : sticky receive error flags
//   tx_level, rx_level     : FIFO occupancy
module uart_fifo_core
  import uart_pkg::*;
#(
  parameter int      DATA_BIT  = 8,
  parameter int      DEPTH     = 16,
  parameter parity_t PARITY    = PAR_NONE,
  parameter int      STOP_BITS = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0]            clkdiv,
  input  logic [DATA_BIT-1:0]    tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   tx,
  input  logic                   rx,
  output logic [DATA_BIT-1:0]    rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  input  logic                   err_clr,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   overrun,
  output logic [$clog2(DEPTH):0] tx_level,
  output logic [$clog2(DEPTH):0] rx_level
);

  localparam logic [3:0] LAST_BIT   = 4'(DATA_BIT - 1);
  localparam logic       LAST_STOP  = 1'(STOP_BITS - 1);
  localparam logic       HAS_PARITY = (PARITY != PAR_NONE);

  function automatic logic parityOf(input logic [DATA_BIT-1:0] d);
    parityOf = (PARITY == PAR_ODD) ? ~(^d) : (^d);
  endfunction

  // ---------------------------------------------------------------- TX path
  logic [DATA_BIT-1:0] txFifoData;
  logic                txFifoFull;
  logic                txFifoEmpty;
  logic                txPush;
  logic                txPop;

  tx_state_t           txState;
  logic [15:0]         txDiv;
  logic [15:0]         txCnt;
  logic [DATA_BIT-1:0] txShift;
  logic [3:0]          txBitIdx;
  logic                txStopIdx;
  logic                txParBit;
  logic                txLine;
  logic                txBitEnd;
  logic                txLoad;

  assign txPush   = tx_valid && tx_ready;
  assign tx_ready = !txFifoFull;
  assign tx       = txLine;
  assign txBitEnd = (txCnt == '0);
  // A new frame starts from IDLE, or straight out of the last stop bit so
  // that queued bytes go out back to back.
  assign txLoad   = !txFifoEmpty &&
                    ((txState == TX_IDLE) ||
                     (txState == TX_STOP && txBitEnd && txStopIdx == LAST_STOP));
  assign txPop    = txLoad;

  uart_sync_fifo #(.WIDTH(DATA_BIT), .DEPTH(DEPTH)) txFifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (txPush),
    .pushData (tx_data),
    .pop      (txPop),
    .popData  (txFifoData),
    .full     (txFifoFull),
    .empty    (txFifoEmpty),
    .level    (tx_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txState   <= TX_IDLE;
      txDiv     <= MIN_CLKDIV;
      txCnt     <= '0;
      txShift   <= '0;
      txBitIdx  <= '0;
      txStopIdx <= 1'b0;
      txParBit  <= 1'b0;
      txLine    <= 1'b1;
    end else if (txLoad) begin
      txState   <= TX_START;
      txDiv     <= effectiveDiv(clkdiv);
      txCnt     <= effectiveDiv(clkdiv) - 16'd1;
      txShift   <= txFifoData;
      txParBit  <= parityOf(txFifoData);
      txLine    <= 1'b0;
    end else if (txState != TX_IDLE) begin
      if (!txBitEnd) begin
        txCnt <= txCnt - 16'd1;
      end else begin
        txCnt <= txDiv - 16'd1;
        case (txState)
          TX_START: begin
            txState  <= TX_DATA;
            txBitIdx <= '0;
            txLine   <= txShift[0];
          end
          TX_DATA: begin
            if (txBitIdx == LAST_BIT) begin
              if (HAS_PARITY) begin
                txState <= TX_PARITY;
                txLine  <= txParBit;
              end else begin
                txState   <= TX_STOP;
                txStopIdx <= 1'b0;
                txLine    <= 1'b1;
              end
            end else begin
              txBitIdx <= txBitIdx + 4'd1;
              txShift  <= txShift >> 1;
              txLine   <= txShift[1];
            end
          end
          TX_PARITY: begin
            txState   <= TX_STOP;
            txStopIdx <= 1'b0;
            txLine    <= 1'b1;
          end
          TX_STOP: begin
            if (txStopIdx != LAST_STOP) begin
              txStopIdx <= 1'b1;
            end else begin
              txState <= TX_IDLE;
            end
          end
          default: txState <= TX_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- RX path
  logic                rxMeta;
  logic                rxSync;
  logic                rxPrev;
  rx_state_t           rxState;
  logic [15:0]         rxDiv;
  logic [15:0]         rxCnt;
  logic [DATA_BIT-1:0] rxShift;
  logic [3:0]          rxBitIdx;
  logic                rxWaitHigh;
  logic                rxSampleNow;
  logic                rxFall;
  logic                rxPush;
  logic                rxFifoFull;
  logic                rxFifoEmpty;
  logic                parSet;
  logic                frameSet;
  logic                overSet;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxSync <= rxMeta;
      rxPrev <= rxSync;
    end
  end

  assign rxFall      = rxPrev && !rxSync;
  assign rxSampleNow = (rxCnt == '0) && !rxWaitHigh;
  assign rxPush      = (rxState == RX_STOP) && rxSampleNow && rxSync;
  assign frameSet    = (rxState == RX_STOP) && rxSampleNow && !rxSync;
  assign parSet      = (rxState == RX_PARITY) && rxSampleNow &&
                       (rxSync != parityOf(rxShift));
  // The FIFO ignores a push while full; the drop is reported here.
  assign overSet     = rxPush && rxFifoFull;
  assign rx_valid    = !rxFifoEmpty;

  uart_sync_fifo #(.WIDTH(DATA_BIT), .DEPTH(DEPTH)) rxFifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (rxPush),
    .pushData (rxShift),
    .pop      (rx_ready),
    .popData  (rx_data),
    .full     (rxFifoFull),
    .empty    (rxFifoEmpty),
    .level    (rx_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxState    <= RX_IDLE;
      rxDiv      <= MIN_CLKDIV;
      rxCnt      <= '0;
      rxShift    <= '0;
      rxBitIdx   <= '0;
      rxWaitHigh <= 1'b0;
    end else begin
      case (rxState)
        RX_IDLE: begin
          if (rxFall) begin
            // First sample lands mid start bit, floor(div/2) cycles on.
            rxState <= RX_START;
            rxDiv   <= effectiveDiv(clkdiv);
            rxCnt   <= (effectiveDiv(clkdiv) >> 1) - 16'd1;
          end
        end
        RX_START: begin
          if (rxCnt != '0) begin
            rxCnt <= rxCnt - 16'd1;
          end else if (rxSync) begin
            rxState <= RX_IDLE;
          end else begin
            rxState  <= RX_DATA;
            rxBitIdx <= '0;
            rxCnt    <= rxDiv - 16'd1;
          end
        end
        RX_DATA: begin
          if (rxCnt != '0) begin
            rxCnt <= rxCnt - 16'd1;
          end else begin
            rxCnt   <= rxDiv - 16'd1;
            rxShift <= {rxSync, rxShift[DATA_BIT-1:1]};
            if (rxBitIdx == LAST_BIT) begin
              rxState <= HAS_PARITY ? RX_PARITY : RX_STOP;
            end else begin
              rxBitIdx <= rxBitIdx + 4'd1;
            end
          end
        end
        RX_PARITY: begin
          if (rxCnt != '0) begin
            rxCnt <= rxCnt - 16'd1;
          end else begin
            rxCnt   <= rxDiv - 16'd1;
            rxState <= RX_STOP;
          end
        end
        RX_STOP: begin
          // After a bad stop bit, hold here until the line is seen high so
          // a stuck-low line cannot start a bogus frame.
          if (rxWaitHigh) begin
            if (rxSync) begin
              rxWaitHigh <= 1'b0;
              rxState    <= RX_IDLE;
            end
          end else if (rxCnt != '0) begin
            rxCnt <= rxCnt - 16'd1;
          end else if (rxSync) begin
            rxState <= RX_IDLE;
          end else begin
            rxWaitHigh <= 1'b1;
          end
        end
        default: rxState <= RX_IDLE;
      endcase
    end
  end

  // Sticky flags: a set event outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= parSet   ? 1'b1 : (err_clr ? 1'b0 : parity_err);
      frame_err  <= frameSet ? 1'b1 : (err_clr ? 1'b0 : frame_err);
      overrun    <= overSet  ? 1'b1 : (err_clr ? 1'b0 : overrun);
    end
  end

endmodule

// File: tb/tb_uart_fifo_core.sv
// tb_uart_fifo_core -- directed bench for uart_fifo_core.
//   dutA: 8N1, DEPTH 16, large divisor for the reference waveform.
//   dutB: 8 data, odd parity, 2 stop bits, DEPTH 4, divisor 16.
module tb_uart_fifo_core;
  import uart_pkg::*;

  localparam int DIV_B = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- dutA
  logic        rstNA = 1'b0;
  logic [15:0] clkdivA = 16'd868;
  logic [7:0]  txDataA = 8'h00;
  logic        txValidA = 1'b0;
  logic        txReadyA;
  logic        txA;
  logic        rxA = 1'b1;
  logic [7:0]  rxDataA;
  logic        rxValidA;
  logic        rxReadyA = 1'b0;
  logic        errClrA = 1'b0;
  logic        peA, feA, ovA;
  logic [4:0]  txLevelA, rxLevelA;

  uart_fifo_core #(.DATA_BIT(8), .DEPTH(16), .PARITY(PAR_NONE), .STOP_BITS(1)) dutA (
    .clk(clk), .rst_n(rstNA), .clkdiv(clkdivA),
    .tx_data(txDataA), .tx_valid(txValidA), .tx_ready(txReadyA), .tx(txA),
    .rx(rxA), .rx_data(rxDataA), .rx_valid(rxValidA), .rx_ready(rxReadyA),
    .err_clr(errClrA), .parity_err(peA), .frame_err(feA), .overrun(ovA),
    .tx_level(txLevelA), .rx_level(rxLevelA)
  );

  // ---------------- dutB
  logic        rstNB = 1'b0;
  logic [15:0] clkdivB = 16'(DIV_B);
  logic [7:0]  txDataB = 8'h00;
  logic        txValidB = 1'b0;
  logic        txReadyB;
  logic        txB;
  logic        rxB;
  logic        rxDrvB = 1'b1;
  logic        loopB = 1'b0;
  logic [7:0]  rxDataB;
  logic        rxValidB;
  logic        rxReadyB = 1'b0;
  logic        errClrB = 1'b0;
  logic        peB, feB, ovB;
  logic [2:0]  txLevelB, rxLevelB;

  assign rxB = loopB ? txB : rxDrvB;

  uart_fifo_core #(.DATA_BIT(8), .DEPTH(4), .PARITY(PAR_ODD), .STOP_BITS(2)) dutB (
    .clk(clk), .rst_n(rstNB), .clkdiv(clkdivB),
    .tx_data(txDataB), .tx_valid(txValidB), .tx_ready(txReadyB), .tx(txB),
    .rx(rxB), .rx_data(rxDataB), .rx_valid(rxValidB), .rx_ready(rxReadyB),
    .err_clr(errClrB), .parity_err(peB), .frame_err(feB), .overrun(ovB),
    .tx_level(txLevelB), .rx_level(rxLevelB)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one serial frame into dutB: start, 8 data LSB first, odd parity,
  // one stop bit, then two bit times of idle.
  task automatic sendFrameB(input logic [7:0] data, input logic badPar, input logic badStop);
    logic p;
    p = ~(^data);
    if (badPar) p = ~p;
    rxDrvB = 1'b0;
    ticks(DIV_B);
    for (int i = 0; i < 8; i++) begin
      rxDrvB = data[i];
      ticks(DIV_B);
    end
    rxDrvB = p;
    ticks(DIV_B);
    rxDrvB = badStop ? 1'b0 : 1'b1;
    ticks(DIV_B);
    rxDrvB = 1'b1;
    ticks(2 * DIV_B);
  endtask

  task automatic popB();
    rxReadyB = 1'b1;
    ticks(1);
    rxReadyB = 1'b0;
  endtask

  task automatic clrB();
    errClrB = 1'b1;
    ticks(1);
    errClrB = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       badPar;
    logic       badStop;
    logic       expValid;
    logic       expPe;
    logic       expFe;
  } vec_t;

  vec_t vecs[5];

  logic expWave[10];
  logic [7:0] loopBytes[3];
  int waited;
  int lowRun;
  int lowCount;

  initial begin
    vecs[0] = '{8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h81, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    expWave = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    loopBytes = '{8'h00, 8'hFF, 8'h3C};

    // ---- reset state
    ticks(3);
    check("rstA tx", txA, 1);
    check("rstA tx_ready", txReadyA, 1);
    check("rstA rx_valid", rxValidA, 0);
    check("rstA rx_data", rxDataA, 0);
    check("rstA flags", {peA, feA, ovA}, 0);
    check("rstA levels", {txLevelA, rxLevelA}, 0);
    check("rstB tx", txB, 1);
    check("rstB flags", {peB, feB, ovB}, 0);
    $display("[TB] reset state checked");
    rstNA = 1'b1;
    rstNB = 1'b1;
    ticks(4);

    // ---- reference waveform 0xA5, 8N1, 868 cycles per bit
    txDataA = 8'hA5;
    txValidA = 1'b1;
    ticks(1);
    txValidA = 1'b0;
    waited = 0;
    while (txA !== 1'b0 && waited < 20) begin
      ticks(1);
      waited++;
    end
    check("waveA start seen", (waited < 20), 1);
    for (int c = 0; c < 10 * 868; c++) begin
      if ((c % 868) == 0 || (c % 868) == 867)
        check($sformatf("waveA bit%0d off%0d", c / 868, c % 868), txA, expWave[c / 868]);
      ticks(1);
    end
    check("waveA idle after frame", txA, 1);
    check("waveA tx_level", txLevelA, 0);
    $display("[TB] waveform 0xA5 checked");

    // ---- divisor below minimum behaves as 4
    clkdivA = 16'd2;
    txDataA = 8'h01;
    txValidA = 1'b1;
    ticks(1);
    txValidA = 1'b0;
    waited = 0;
    while (txA !== 1'b0 && waited < 20) begin
      ticks(1);
      waited++;
    end
    lowRun = 0;
    while (txA === 1'b0 && lowRun < 50) begin
      ticks(1);
      lowRun++;
    end
    check("min div start bit length", lowRun, 4);
    $display("[TB] clkdiv=2 start bit length %0d", lowRun);
    ticks(60);

    // ---- table-driven injected frames on dutB
    for (int i = 0; i < 5; i++) begin
      sendFrameB(vecs[i].data, vecs[i].badPar, vecs[i].badStop);
      check($sformatf("vec%0d rx_valid", i), rxValidB, vecs[i].expValid);
      check($sformatf("vec%0d rx_data", i), rxDataB, vecs[i].expValid ? vecs[i].data : 8'h00);
      check($sformatf("vec%0d parity_err", i), peB, vecs[i].expPe);
      check($sformatf("vec%0d frame_err", i), feB, vecs[i].expFe);
      $display("[TB] vec %0d data=%02h badPar=%0d badStop=%0d valid=%0d pe=%0d fe=%0d",
               i, vecs[i].data, vecs[i].badPar, vecs[i].badStop, rxValidB, peB, feB);
      popB();
      clrB();
      check($sformatf("vec%0d flags after clr", i), {peB, feB, ovB}, 0);
      check($sformatf("vec%0d empty after pop", i), rxValidB, 0);
    end

    // ---- odd-parity loopback, three back-to-back frames
    loopB = 1'b1;
    ticks(4);
    for (int i = 0; i < 3; i++) begin
      txDataB = loopBytes[i];
      txValidB = 1'b1;
      ticks(1);
    end
    txValidB = 1'b0;
    ticks(3 * 12 * DIV_B + 80);
    check("loop rx_level", rxLevelB, 3);
    check("loop tx_level", txLevelB, 0);
    check("loop parity_err", peB, 0);
    check("loop frame_err", feB, 0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("loop byte%0d", i), rxDataB, loopBytes[i]);
      $display("[TB] loopback byte %0d = %02h", i, rxDataB);
      popB();
    end
    loopB = 1'b0;
    ticks(4);

    // ---- overrun: DEPTH+1 frames with no reader
    for (int i = 0; i < 5; i++) begin
      sendFrameB(8'((i + 1) * 8'h11), 1'b0, 1'b0);
      $display("[TB] overrun frame %0d sent, rx_level=%0d", i, rxLevelB);
    end
    check("ovr rx_level", rxLevelB, 4);
    check("ovr overrun", ovB, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovr byte%0d", i), rxDataB, 8'((i + 1) * 8'h11));
      popB();
    end
    check("ovr empty after drain", rxValidB, 0);
    clrB();
    check("ovr cleared", ovB, 0);

    // ---- short low glitch (div/4)
    rxDrvB = 1'b0;
    ticks(DIV_B / 4);
    rxDrvB = 1'b1;
    ticks(4 * DIV_B);
    check("glitch rx_valid", rxValidB, 0);
    check("glitch flags", {peB, feB, ovB}, 0);
    $display("[TB] glitch applied, rx_valid=%0d", rxValidB);

    // ---- reset in the middle of a TX frame
    for (int i = 0; i < 2; i++) begin
      txDataB = 8'h00;
      txValidB = 1'b1;
      ticks(1);
    end
    txValidB = 1'b0;
    ticks(40);
    check("midrst tx low before reset", txB, 0);
    rstNB = 1'b0;
    #1;
    check("midrst tx high", txB, 1);
    check("midrst tx_level", txLevelB, 0);
    check("midrst tx_ready", txReadyB, 1);
    ticks(2);
    rstNB = 1'b1;
    lowCount = 0;
    for (int i = 0; i < 4 * DIV_B; i++) begin
      ticks(1);
      if (txB !== 1'b1) lowCount++;
    end
    check("midrst tx idle after release", lowCount, 0);
    $display("[TB] mid-frame reset checked");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_fifo_core.md
UART_FIFO_CORE -- requirements
Module: uart_fifo_core

Interface
REQ-001 Parameter DATA_BIT, 8, payload bits per frame, legal range 5..9.
REQ-002 Parameter DEPTH, 16, entries per TX and RX FIFO, power of two, at least 2.
REQ-003 Parameter PARITY, PAR_NONE, parity mode from uart_pkg: PAR_NONE, PAR_EVEN or PAR_ODD.
REQ-004 Parameter STOP_BITS, 1, stop bits per transmitted frame, 1 or 2.
REQ-005 Ports clk and rst_n shall be the first ports: one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  system clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 clkdiv  in  16  clock cycles per bit; values below 4 are treated as 4.
REQ-009 tx_data  in  DATA_BIT  byte to enqueue for transmission.
REQ-010 tx_valid  in  1  enqueue request; a push occurs when tx_valid and tx_ready are both high.
REQ-011 tx_ready  out  1  high when the TX FIFO is not full.
REQ-012 tx  out  1  serial line output, idle high.
REQ-013 rx  in  1  asynchronous serial input.
REQ-014 rx_data  out  DATA_BIT  head of the RX FIFO.
REQ-015 rx_valid  out  1  high when the RX FIFO is not empty.
REQ-016 rx_ready  in  1  dequeue; a pop occurs when rx_valid and rx_ready are both high.
REQ-017 err_clr  in  1  one-cycle pulse that clears all sticky error flags.
REQ-018 parity_err, frame_err, overrun  out  1 each  sticky error flags.
REQ-019 tx_level, rx_level  out  $clog2(DEPTH)+1 each  FIFO occupancy.

Function
REQ-020 TX FSM states: IDLE, START, DATA, PARITY, STOP; each bit lasts exactly one latched clkdiv.
REQ-021 In IDLE with the TX FIFO non-empty: pop one entry, latch clkdiv, drive tx low on the next cycle, and enter START.
REQ-022 TX bit order: one start bit (0), data LSB first, a parity bit only when PARITY is not PAR_NONE, then STOP_BITS stop bits (1).
REQ-023 Parity bit: XOR of the data bits for PAR_EVEN; inverted XOR for PAR_ODD.
REQ-024 After the final stop bit, TX shall start the next frame without an idle gap if the FIFO is non-empty.
REQ-025 clkdiv is latched at frame start for both TX and RX; a change mid-frame takes effect from the next frame.
REQ-026 rx shall pass through a two-flop synchroniser before any use.
REQ-027 RX FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-028 RX IDLE: a synchronised falling edge enters START; START samples at clkdiv/2 (floor).
REQ-029 If the START sample is high, the event is a glitch: return to IDLE with no flag set.
REQ-030 After START, RX samples each subsequent bit one clkdiv later; RX checks exactly one stop bit regardless of STOP_BITS.
REQ-031 If the stop sample is 0, set frame_err and discard the byte; RX then returns to IDLE only after rx is sampled high.
REQ-032 If the parity sample mismatches, set parity_err and still enqueue the byte.
REQ-033 A completed byte arriving while the RX FIFO is full is dropped, overrun is set, and the FIFO contents are unchanged.
REQ-034 rx_data of a byte becomes valid in the cycle after its stop-bit sample.
REQ-035 Simultaneous push and pop on a FIFO: allowed at any level except a pop on empty, and the level is unchanged; when full, tx_ready is low, so no push can occur.
REQ-036 The FIFO pointers wrap modulo DEPTH.
REQ-037 Sticky flags set on their event and clear only on err_clr; a set event in the same cycle as err_clr wins.

Reset
REQ-038 While rst_n is low: tx=1, tx_ready=1, rx_valid=0, rx_data=0, all error flags 0, both levels 0, both FSMs in IDLE.
REQ-039 Reset mid-frame aborts the frame immediately; tx goes high asynchronously; the partial RX byte is discarded.

Structure
REQ-040 uart_pkg shall hold the parity enum, the TX and RX state enums, and the minimum divisor constant (4).
REQ-041 One sub-module, uart_sync_fifo (parameters WIDTH and DEPTH), shall be instantiated once for TX and once for RX.

Verification
REQ-042 DATA_BIT=8, PAR_NONE, clkdiv=868, push 0xA5 -> tx waveform 0,1,0,1,0,0,1,0,1,1, each bit 868 cycles.
REQ-043 PAR_ODD loopback (tx tied to rx), push 0x00,0xFF,0x3C -> the same bytes are received in order, with parity_err=0.
REQ-044 Inject a frame with a wrong parity bit -> parity_err=1 and the byte is enqueued; err_clr -> parity_err=0.
REQ-045 With rx_ready=0, send DEPTH+1 frames -> rx_level=DEPTH, overrun=1, and the first DEPTH bytes are intact.
REQ-046 A rx low glitch of clkdiv/4 -> no byte is received and no flag is set.
REQ-047 Assert rst_n low mid-TX frame -> tx=1 within the same cycle, tx_level=0, and the FSM is in IDLE.
